// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - IF/ID pipeline register with immediate-field slicer and extender select
//
// Purpose:
//   Holds one fetched instruction and its PC between the fetch unit and the ID
//   stage. Acceptance uses a valid/ready handshake. The ID side can stall the
//   stage. A branch/jump redirect flushes it. From the held instruction the
//   stage slices the six raw immediate fields. It also decodes the one-hot
//   EXTOp select used by the ID-stage immediate extender.
//
// Optional feature:
//   IFID_ILLEGAL_DET_EN - when defined, adds the `illegal` output. It flags a
//   valid held instruction whose opcode is not an RV32I opcode.
//
// Ports:
//   clk         in   1      rising-edge clock
//   rst         in   1      synchronous active-high reset
//   in_valid    in   1      fetch offers an instruction
//   in_ready    out  1      stage accepts this cycle (!out_valid || out_ready)
//   in_pc       in   PC_W   PC of offered instruction
//   in_instr    in   32     offered instruction
//   flush       in   1      kill held and offered instruction
//   out_valid   out  1      held instruction valid toward ID
//   out_ready   in   1      ID consumes held instruction (low = stall)
//   pc_out      out  PC_W   held PC
//   instr_out   out  32     held instruction
//   iimm_shamt  out  5      instr_out[24:20]
//   iimm        out  12     instr_out[31:20]
//   simm        out  12     {instr_out[31:25], instr_out[11:7]}
//   bimm        out  12     {instr_out[31], instr_out[7], instr_out[30:25], instr_out[11:8]}
//   uimm        out  20     instr_out[31:12]
//   jimm        out  20     {instr_out[31], instr_out[19:12], instr_out[20], instr_out[30:21]}
//   EXTOp       out  6      one-hot extender select, zero when out_valid=0
//   illegal     out  1      (IFID_ILLEGAL_DET_EN only) illegal opcode held

module if_id_stage #(
  parameter int          PC_W      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PC_W-1:0] in_pc,
  input  logic [31:0]     in_instr,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] pc_out,
  output logic [31:0]     instr_out,
  output logic [4:0]      iimm_shamt,
  output logic [11:0]     iimm,
  output logic [11:0]     simm,
  output logic [11:0]     bimm,
  output logic [19:0]     uimm,
  output logic [19:0]     jimm,
  output logic [5:0]      EXTOp
`ifdef IFID_ILLEGAL_DET_EN
  ,
  output logic            illegal
`endif
);

  // One-hot extender select encodings shared with the ID-stage extender.
  localparam logic [5:0] EXT_CTRL_ITYPE_SHAMT = 6'b000001;
  localparam logic [5:0] EXT_CTRL_ITYPE       = 6'b000010;
  localparam logic [5:0] EXT_CTRL_STYPE       = 6'b000100;
  localparam logic [5:0] EXT_CTRL_BTYPE       = 6'b001000;
  localparam logic [5:0] EXT_CTRL_UTYPE       = 6'b010000;
  localparam logic [5:0] EXT_CTRL_JTYPE       = 6'b100000;

  // RV32I major opcodes.
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
`ifdef IFID_ILLEGAL_DET_EN
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_FENCE = 7'b0001111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;
`endif

  // funct3 values that select the shift-immediate forms of OP-IMM.
  localparam logic [2:0] F3_SLLI  = 3'b001;
  localparam logic [2:0] F3_SRXI  = 3'b101;

  logic       load_en;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [5:0] ext_sel;

  // Ready depends only on held state, never on in_valid or flush. This keeps
  // the fetch-side handshake free of combinational loops.
  assign in_ready = !out_valid || out_ready;
  assign load_en  = in_valid && in_ready;

  // Pipeline register. Flush outranks everything except reset. An offered
  // instruction is dropped even when the handshake would have accepted it.
  // pc_out is left alone on flush because nothing downstream reads it while
  // out_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      pc_out    <= '0;
      instr_out <= NOP_INSTR;
    end else if (flush) begin
      out_valid <= 1'b0;
      instr_out <= NOP_INSTR;
    end else if (load_en) begin
      out_valid <= 1'b1;
      pc_out    <= in_pc;
      instr_out <= in_instr;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Raw immediate fields. They are sliced without sign extension, which the
  // ID-stage extender applies according to EXTOp.
  assign iimm_shamt = instr_out[24:20];
  assign iimm       = instr_out[31:20];
  assign simm       = {instr_out[31:25], instr_out[11:7]};
  assign bimm       = {instr_out[31], instr_out[7], instr_out[30:25], instr_out[11:8]};
  assign uimm       = instr_out[31:12];
  assign jimm       = {instr_out[31], instr_out[19:12], instr_out[20], instr_out[30:21]};

  assign opcode = instr_out[6:0];
  assign funct3 = instr_out[14:12];

  always_comb begin
    ext_sel = 6'b0;
    unique case (opcode)
      OP_IMM: begin
        if (funct3 == F3_SLLI || funct3 == F3_SRXI) begin
          ext_sel = EXT_CTRL_ITYPE_SHAMT;
        end else begin
          ext_sel = EXT_CTRL_ITYPE;
        end
      end
      OP_LOAD, OP_JALR: ext_sel = EXT_CTRL_ITYPE;
      OP_STORE:         ext_sel = EXT_CTRL_STYPE;
      OP_BR:            ext_sel = EXT_CTRL_BTYPE;
      OP_LUI, OP_AUIPC: ext_sel = EXT_CTRL_UTYPE;
      OP_JAL:           ext_sel = EXT_CTRL_JTYPE;
      default:          ext_sel = 6'b0;
    endcase
  end

  // A bubble (including the NOP left by reset/flush) must not steer the
  // extender.
  assign EXTOp = out_valid ? ext_sel : 6'b0;

`ifdef IFID_ILLEGAL_DET_EN
  logic opcode_legal;

  always_comb begin
    opcode_legal = 1'b0;
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR, OP_STORE, OP_BR,
      OP_LUI, OP_AUIPC, OP_JAL, OP_REG, OP_FENCE, OP_SYS: opcode_legal = 1'b1;
      default:                                             opcode_legal = 1'b0;
    endcase
  end

  assign illegal = out_valid && !opcode_legal;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - randomized self-checking bench for if_id_stage against a queue model

module tb_if_id_stage;

  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [5:0]  E_SH = 6'b000001;
  localparam logic [5:0]  E_I  = 6'b000010;
  localparam logic [5:0]  E_S  = 6'b000100;
  localparam logic [5:0]  E_B  = 6'b001000;
  localparam logic [5:0]  E_U  = 6'b010000;
  localparam logic [5:0]  E_J  = 6'b100000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic [4:0]  iimm_shamt;
  logic [11:0] iimm;
  logic [11:0] simm;
  logic [11:0] bimm;
  logic [19:0] uimm;
  logic [19:0] jimm;
  logic [5:0]  ext_op;
`ifdef IFID_ILLEGAL_DET_EN
  logic        illegal;
`endif

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  if_id_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pc      (in_pc),
    .in_instr   (in_instr),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .pc_out     (pc_out),
    .instr_out  (instr_out),
    .iimm_shamt (iimm_shamt),
    .iimm       (iimm),
    .simm       (simm),
    .bimm       (bimm),
    .uimm       (uimm),
    .jimm       (jimm),
    .EXTOp      (ext_op)
`ifdef IFID_ILLEGAL_DET_EN
    ,
    .illegal    (illegal)
`endif
  );

  // ---------------- behavioural model ----------------
  // The stage is a one-entry queue. shown_* is what the register outputs
  // display; it persists after the entry has been consumed.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        slot[$];
  logic [31:0] shown_pc;
  logic [31:0] shown_instr;

  always @(posedge clk) begin
    bit give;
    bit take;
    if (rst) begin
      slot.delete();
      shown_pc    = 32'h0;
      shown_instr = NOP;
    end else begin
      give = (slot.size() != 0) && out_ready;
      take = in_valid && (slot.size() == 0 || out_ready);
      if (flush) begin
        slot.delete();
        shown_instr = NOP;
      end else begin
        if (give) void'(slot.pop_front());
        if (take) begin
          slot.push_back({in_pc, in_instr});
          shown_pc    = in_pc;
          shown_instr = in_instr;
        end
      end
    end
  end

  // Full RISC-V immediates, from which the raw fields are then recovered.
  function automatic logic [31:0] imm_i(input logic [31:0] w);
    return {{20{w[31]}}, w[31:20]};
  endfunction
  function automatic logic [31:0] imm_s(input logic [31:0] w);
    return {{20{w[31]}}, w[31:25], w[11:7]};
  endfunction
  function automatic logic [31:0] imm_b(input logic [31:0] w);
    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
  endfunction
  function automatic logic [31:0] imm_u(input logic [31:0] w);
    return {w[31:12], 12'b0};
  endfunction
  function automatic logic [31:0] imm_j(input logic [31:0] w);
    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
  endfunction

  function automatic logic [5:0] ref_ext(input logic [31:0] w);
    logic [6:0] op;
    logic [2:0] f3;
    op = w[6:0];
    f3 = w[14:12];
    if (op == 7'h13) return (f3 == 3'd1 || f3 == 3'd5) ? E_SH : E_I;
    if (op == 7'h03 || op == 7'h67) return E_I;
    if (op == 7'h23) return E_S;
    if (op == 7'h63) return E_B;
    if (op == 7'h37 || op == 7'h17) return E_U;
    if (op == 7'h6F) return E_J;
    return 6'b0;
  endfunction

  function automatic bit ref_legal(input logic [31:0] w);
    logic [6:0] legal_ops [11];
    legal_ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F,
                  7'h33, 7'h0F, 7'h73};
    foreach (legal_ops[k]) if (legal_ops[k] == w[6:0]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: checks every output against the model on every cycle.
  always @(negedge clk) begin
    logic        mv;
    logic [31:0] t;
    if (chk_en) begin
      mv = (slot.size() != 0);
      chk("out_valid", {31'b0, out_valid}, {31'b0, mv});
      chk("in_ready", {31'b0, in_ready}, {31'b0, (!mv || out_ready)});
      chk("pc_out", pc_out, shown_pc);
      chk("instr_out", instr_out, shown_instr);
      t = imm_i(shown_instr);
      chk("iimm", {20'b0, iimm}, {20'b0, t[11:0]});
      chk("iimm_shamt", {27'b0, iimm_shamt}, {27'b0, t[4:0]});
      t = imm_s(shown_instr);
      chk("simm", {20'b0, simm}, {20'b0, t[11:0]});
      t = imm_b(shown_instr);
      chk("bimm", {20'b0, bimm}, {20'b0, t[12:1]});
      t = imm_u(shown_instr);
      chk("uimm", {12'b0, uimm}, {12'b0, t[31:12]});
      t = imm_j(shown_instr);
      chk("jimm", {12'b0, jimm}, {12'b0, t[20:1]});
      chk("EXTOp", {26'b0, ext_op}, {26'b0, (mv ? ref_ext(shown_instr) : 6'b0)});
`ifdef IFID_ILLEGAL_DET_EN
      chk("illegal", {31'b0, illegal}, {31'b0, (mv && !ref_legal(shown_instr))});
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                        input logic fl, input logic ordy);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = ins;
    flush     = fl;
    out_ready = ordy;
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [13];
    logic [31:0] r;
    ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F,
            7'h33, 7'h0F, 7'h73, 7'h7F, 7'h00};
    r = $urandom();
    if ($urandom_range(0, 7) == 0) return r;
    return {r[31:7], ops[$urandom_range(0, 12)]};
  endfunction

  initial begin
    rst = 1'b1;
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    chk_en = 1'b1;
    tick();
    // reset state
    chk("rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst instr_out", instr_out, 32'h00000013);
    chk("rst pc_out", pc_out, 32'h0);
    chk("rst EXTOp", {26'b0, ext_op}, 32'd0);
    chk("rst in_ready", {31'b0, in_ready}, 32'd1);
`ifdef IFID_ILLEGAL_DET_EN
    chk("rst illegal", {31'b0, illegal}, 32'd0);
`endif
    rst = 1'b0;

    // decode, one per cycle
    set_in(1'b1, 32'h0, 32'hFFF00093, 1'b0, 1'b1); tick();
    chk("dec addi EXTOp", {26'b0, ext_op}, {26'b0, E_I});
    chk("dec addi iimm", {20'b0, iimm}, 32'hFFF);
    set_in(1'b1, 32'h4, 32'h00309093, 1'b0, 1'b1); tick();
    chk("dec slli EXTOp", {26'b0, ext_op}, {26'b0, E_SH});
    chk("dec slli shamt", {27'b0, iimm_shamt}, 32'd3);
    set_in(1'b1, 32'h8, 32'h0020A423, 1'b0, 1'b1); tick();
    chk("dec sw EXTOp", {26'b0, ext_op}, {26'b0, E_S});
    chk("dec sw simm", {20'b0, simm}, 32'h008);
    set_in(1'b1, 32'hC, 32'h123452B7, 1'b0, 1'b1); tick();
    chk("dec lui EXTOp", {26'b0, ext_op}, {26'b0, E_U});
    chk("dec lui uimm", {12'b0, uimm}, 32'h12345);
    set_in(1'b1, 32'h10, 32'h008000EF, 1'b0, 1'b1); tick();
    chk("dec jal EXTOp", {26'b0, ext_op}, {26'b0, E_J});
    chk("dec jal jimm", {12'b0, jimm}, 32'h00004);
    set_in(1'b1, 32'h14, 32'h00000463, 1'b0, 1'b1); tick();
    chk("dec beq EXTOp", {26'b0, ext_op}, {26'b0, E_B});
    chk("dec beq bimm", {20'b0, bimm}, 32'h004);

    // stall
    set_in(1'b1, 32'h100, 32'h00100093, 1'b0, 1'b1); tick();
    chk("stall load pc", pc_out, 32'h100);
    set_in(1'b1, 32'h104, 32'h00200093, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("stall in_ready", {31'b0, in_ready}, 32'd0);
      tick();
      chk("stall pc_out", pc_out, 32'h100);
      chk("stall out_valid", {31'b0, out_valid}, 32'd1);
    end
    set_in(1'b1, 32'h104, 32'h00200093, 1'b0, 1'b1);
    chk("unstall in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    chk("unstall pc_out", pc_out, 32'h104);

    // flush
    set_in(1'b1, 32'h104, 32'h008000EF, 1'b0, 1'b1); tick();
    chk("flush held EXTOp", {26'b0, ext_op}, {26'b0, E_J});
    set_in(1'b1, 32'h108, 32'h00300093, 1'b1, 1'b1); tick();
    chk("flush out_valid", {31'b0, out_valid}, 32'd0);
    chk("flush instr_out", instr_out, 32'h00000013);
    chk("flush EXTOp", {26'b0, ext_op}, 32'd0);
    chk("flush pc hold", pc_out, 32'h104);
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b1); tick();
    chk("flush no 0x108", {31'b0, out_valid}, 32'd0);

    // flush during stall
    set_in(1'b1, 32'h180, 32'h00400093, 1'b0, 1'b1); tick();
    set_in(1'b0, 32'h0, 32'h0, 1'b1, 1'b0); tick();
    chk("flush+stall out_valid", {31'b0, out_valid}, 32'd0);

    // back-to-back
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, 32'h200 + 32'(4 * i), 32'h00000093 | (32'(i) << 20), 1'b0, 1'b1);
      tick();
      chk("b2b out_valid", {31'b0, out_valid}, 32'd1);
      chk("b2b pc order", pc_out, 32'h200 + 32'(4 * i));
    end
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b1); tick();
    chk("b2b drain", {31'b0, out_valid}, 32'd0);
    chk("b2b drain pc hold", pc_out, 32'h21C);

    // reset mid-stall
    set_in(1'b1, 32'h300, 32'h00500093, 1'b0, 1'b1); tick();
    set_in(1'b1, 32'h304, 32'h00600093, 1'b0, 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst-stall out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst-stall pc_out", pc_out, 32'h0);

`ifdef IFID_ILLEGAL_DET_EN
    set_in(1'b1, 32'h400, 32'h0000007F, 1'b0, 1'b1); tick();
    chk("ill 7F illegal", {31'b0, illegal}, 32'd1);
    chk("ill 7F EXTOp", {26'b0, ext_op}, 32'd0);
    set_in(1'b1, 32'h404, 32'h00000033, 1'b0, 1'b1); tick();
    chk("ill 33 illegal", {31'b0, illegal}, 32'd0);
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b1); tick();
    chk("ill bubble", {31'b0, illegal}, 32'd0);
`endif

    // randomized traffic; the compare process checks every cycle
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      set_in(1'($urandom_range(0, 3) != 0),
             32'($urandom_range(0, 32'h3FFF)) << 2,
             rand_instr(),
             1'($urandom_range(0, 11) == 0),
             1'($urandom_range(0, 9) < 7));
      tick();
    end
    rst = 1'b0;
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
